// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with shift ops, carry flag and handshaked issue/result
// Define ALU_MUL_EN to build the multi-cycle shift-add multiplier for op 111.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       status,
  output logic             carry,
  output logic             out_err
);
  localparam int M = WIDTH - 1;

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, acc_next;
  logic [CW-1:0]    cnt_q, cnt_d;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [2:0]       status_q, status_d;
  logic             carry_q, carry_d, err_q, err_d;
  logic             accept;

  logic [WIDTH:0]   alu_sum;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c, alu_v, alu_err;

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign status    = status_q;
  assign carry     = carry_q;
  assign out_err   = err_q;

  // Single-cycle ops; op 111 is resolved here only when the multiplier is absent.
  always_comb begin
    alu_sum = '0;
    alu_r   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (op)
      3'b000: begin
        alu_sum = {1'b0, a} + {1'b0, b};
        alu_r   = alu_sum[M:0];
        alu_c   = alu_sum[WIDTH];
        alu_v   = (a[M] == b[M]) && (alu_r[M] != a[M]);
      end
      3'b001: begin
        alu_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        alu_r   = alu_sum[M:0];
        alu_c   = alu_sum[WIDTH];
        alu_v   = (a[M] != b[M]) && (alu_r[M] != a[M]);
      end
      3'b010: alu_r = a & b;
      3'b011: alu_r = ~b;
      3'b100: begin
        alu_r = {b[M-1:0], 1'b0};
        alu_c = b[M];
      end
      3'b101: begin
        alu_r = {1'b0, b[M:1]};
        alu_c = b[0];
      end
      3'b110: begin
        alu_r = {b[M], b[M:1]};
        alu_c = b[0];
      end
      default: begin
`ifndef ALU_MUL_EN
        alu_err = 1'b1;
`endif
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    status_d = status_q;
    carry_d  = carry_q;
    err_d    = err_q;
`ifdef ALU_MUL_EN
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    if (state_q == BUSY) begin
      acc_d    = acc_next;
      mcand_d  = {mcand_q[M-1:0], 1'b0};
      mplier_d = {1'b0, mplier_q[M:1]};
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        state_d  = DONE;
        result_d = acc_next;
        status_d = {acc_next[M], 1'b0, acc_next == '0};
        carry_d  = 1'b0;
        err_d    = 1'b0;
      end
    end
`endif
    if ((state_q == DONE) && out_ready)
      state_d = IDLE;
    if (accept) begin
`ifdef ALU_MUL_EN
      if (op == 3'b111) begin
        state_d  = BUSY;
        acc_d    = '0;
        mcand_d  = a;
        mplier_d = b;
        cnt_d    = '0;
      end else
`endif
      begin
        state_d  = DONE;
        result_d = alu_r;
        status_d = {alu_r[M], alu_v, alu_r == '0};
        carry_d  = alu_c;
        err_d    = alu_err;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      status_q <= '0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef ALU_MUL_EN
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      status_q <= status_d;
      carry_q  <= carry_d;
      err_q    <= err_d;
`ifdef ALU_MUL_EN
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq at WIDTH=16
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'b000;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] result;
  logic [2:0]  status;
  logic        carry;
  logic        out_err;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .status(status), .carry(carry), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic [2:0]  st;
    logic        c;
  } vec_t;

  // Present one op at a negedge, let it be accepted, return at the next negedge.
  task automatic do_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                       input logic ordy);
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1; out_ready = ordy;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (result !== 16'h0) begin errors++; $display("FAIL reset_result got %h want 0000", result); end
    checks++; if ({status, carry, out_err} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b want 00000", {status, carry, out_err}); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_arith;
    vec_t v[$];
    v.push_back('{3'b001, 16'd12,   16'd20,   16'hFFF8, 3'b100, 1'b0});
    v.push_back('{3'b000, 16'h7FFF, 16'h7FFF, 16'hFFFE, 3'b110, 1'b0});
    v.push_back('{3'b001, 16'h82D3, 16'h4F64, 16'd13167, 3'b010, 1'b1});
    v.push_back('{3'b101, 16'h1234, 16'h0001, 16'h0000, 3'b001, 1'b1});
    v.push_back('{3'b110, 16'h0000, 16'h8000, 16'hC000, 3'b100, 1'b0});
    v.push_back('{3'b010, 16'hF0F0, 16'hFF00, 16'hF000, 3'b100, 1'b0});
    v.push_back('{3'b011, 16'h5555, 16'hFFFF, 16'h0000, 3'b001, 1'b0});
    v.push_back('{3'b100, 16'h0000, 16'h8001, 16'h0002, 3'b000, 1'b1});
    v.push_back('{3'b000, 16'hFFFF, 16'h0001, 16'h0000, 3'b001, 1'b1});
    v.push_back('{3'b001, 16'h0005, 16'h0005, 16'h0000, 3'b001, 1'b1});
    v.push_back('{3'b001, 16'h8000, 16'h0001, 16'h7FFF, 3'b010, 1'b1});
    foreach (v[i]) begin
      do_op(v[i].op, v[i].a, v[i].b, 1'b1);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arith_valid[%0d] got %b want 1", i, out_valid); end
      checks++; if (result !== v[i].r) begin errors++; $display("FAIL arith_result[%0d] got %h want %h", i, result, v[i].r); end
      checks++; if (status !== v[i].st) begin errors++; $display("FAIL arith_status[%0d] got %b want %b", i, status, v[i].st); end
      checks++; if (carry !== v[i].c) begin errors++; $display("FAIL arith_carry[%0d] got %b want %b", i, carry, v[i].c); end
      checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL arith_err[%0d] got %b want 0", i, out_err); end
    end
  endtask

  task automatic test_mul;
    int n;
`ifdef ALU_MUL_EN
    logic [15:0] ma[3] = '{16'd300, 16'hFFFF, 16'h0000};
    logic [15:0] mb[3] = '{16'd300, 16'hFFFF, 16'h1234};
    logic [15:0] mr[3] = '{16'h5F90, 16'h0001, 16'h0000};
    logic [2:0]  ms[3] = '{3'b000, 3'b000, 3'b001};
    for (int k = 0; k < 3; k++) begin
      do_op(3'b111, ma[k], mb[k], 1'b1);
      n = 1;
      while (out_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      checks++; if (n != 17) begin errors++; $display("FAIL mul_latency[%0d] got %0d want 17", k, n); end
      checks++; if (result !== mr[k]) begin errors++; $display("FAIL mul_result[%0d] got %h want %h", k, result, mr[k]); end
      checks++; if ({status, carry, out_err} !== {ms[k], 2'b00}) begin errors++; $display("FAIL mul_flags[%0d] got %b want %b", k, {status, carry, out_err}, {ms[k], 2'b00}); end
    end
`else
    do_op(3'b111, 16'd300, 16'd300, 1'b1);
    n = 1;
    while (out_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++; if (n != 1) begin errors++; $display("FAIL mul_latency got %0d want 1", n); end
    checks++; if (result !== 16'h0) begin errors++; $display("FAIL mul_result got %h want 0000", result); end
    checks++; if ({status, carry, out_err} !== 5'b00101) begin errors++; $display("FAIL mul_flags got %b want 00101", {status, carry, out_err}); end
`endif
  endtask

  task automatic test_hold;
    do_op(3'b000, 16'd3, 16'd4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      op = 3'(i + 1); a = 16'($urandom); b = 16'($urandom); in_valid = 1'b1;
      @(negedge clk);
      checks++; if ({out_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL hold_hs[%0d] got %b want 10", i, {out_valid, in_ready}); end
      checks++; if ({result, status, carry, out_err} !== {16'd7, 5'b00000}) begin errors++; $display("FAIL hold_data[%0d] got %h/%b want 0007/00000", i, result, {status, carry, out_err}); end
    end
    op = 3'b010; a = 16'hFF00; b = 16'h0F0F; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready got %b want 1", in_ready); end
    @(posedge clk);
    #1 in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_b2b_valid got %b want 1", out_valid); end
    @(negedge clk);
    checks++; if ({out_valid, result, status} !== {1'b1, 16'h0F00, 3'b000}) begin errors++; $display("FAIL hold_b2b_result got %b/%h/%b want 1/0f00/000", out_valid, result, status); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [2:0]  bo[3] = '{3'b000, 3'b001, 3'b100};
    logic [15:0] ba[3] = '{16'd1, 16'd10, 16'd0};
    logic [15:0] bb[3] = '{16'd2, 16'd3, 16'h4000};
    logic [15:0] br[3] = '{16'd3, 16'd7, 16'h8000};
    logic [3:0]  bf[3] = '{4'b0000, 4'b0001, 4'b1000};
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op = bo[i]; a = ba[i]; b = bb[i]; in_valid = 1'b1;
      @(negedge clk);
      checks++; if ({out_valid, result, status, carry} !== {1'b1, br[i], bf[i]}) begin errors++; $display("FAIL b2b[%0d] got %b/%h/%b want 1/%h/%b", i, out_valid, result, {status, carry}, br[i], bf[i]); end
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", out_valid); end
  endtask

  task automatic test_reset_abort;
    int seen;
    do_op(3'b000, 16'd1, 16'd1, 1'b0);
    reset = 1'b1;
    #1;
    checks++; if ({out_valid, in_ready, result} !== {2'b01, 16'h0}) begin errors++; $display("FAIL rst_done got %b/%b/%h want 0/1/0000", out_valid, in_ready, result); end
    @(negedge clk); reset = 1'b0;
`ifdef ALU_MUL_EN
    do_op(3'b000, 16'd9, 16'd9, 1'b1);
    do_op(3'b111, 16'd300, 16'd300, 1'b1);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if ({out_valid, result} !== {1'b0, 16'h0}) begin errors++; $display("FAIL rst_mul got %b/%h want 0/0000", out_valid, result); end
    @(negedge clk); reset = 1'b0;
`endif
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rst_stale got %0d valid cycles want 0", seen); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", in_ready); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_arith;
    test_mul;
    test_hold;
    test_back_to_back;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
